// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the five-stage pipeline.
//
// Detects load-use hazards against ID/EX, tracks the multi-cycle HI/LO unit
// with a busy counter, and sequences the pipeline registers. An EX redirect
// overrides both stall sources. A saturating counter records stalled cycles.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_rs, id_rt         source register fields of the instruction in ID
//   id_use_rs, id_use_rt ID instruction actually reads rs / rt
//   id_md                ID instruction touches the HI/LO unit
//   ex_load, ex_rd       ID/EX holds a load writing ex_rd
//   ex_md_start          EX starts a multiply/divide this cycle
//   ex_redirect          branch taken / jump resolved in EX
//   PCWr, IFIDWr         PC and IF/ID write enables
//   IFIDFlush, IDEXFlush flush strobes for IF/ID and ID/EX
//   md_busy              HI/LO unit busy
//   stall_cnt            saturating count of PCWr=0 cycles since reset
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_md,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_md_start,
    input  logic        ex_redirect,
    output logic        PCWr,
    output logic        IFIDWr,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [15:0]      stall_cnt_q;
    logic             load_use;
    logic             md_stall;

    // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_load && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign md_stall = (state_q == StMdWait) && id_md;

    // A start while already waiting is ignored; the count is never reloaded.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            StRun: begin
                if (ex_md_start) begin
                    state_d  = StMdWait;
                    md_cnt_d = CNT_W'(MD_LAT);
                end
            end
            StMdWait: begin
                if (md_cnt_q == CNT_W'(1)) begin
                    state_d  = StRun;
                    md_cnt_d = '0;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = '0;
            end
        endcase
    end

    // Redirect wins over stalls: the EX instruction is older, so whatever is
    // in IF and ID is on the wrong path and gets killed instead of held.
    always_comb begin
        PCWr      = 1'b1;
        IFIDWr    = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (rst) begin
            PCWr      = 1'b0;
            IFIDWr    = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (ex_redirect) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (md_stall || load_use) begin
            PCWr      = 1'b0;
            IFIDWr    = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (!PCWr && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign md_busy   = (state_q == StMdWait);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It generates the PC write enable, IF/ID write enable and the IF/ID and ID/EX flush strobes that sequence the pipeline registers. It detects load-use hazards against the ID/EX stage and tracks the multi-cycle multiply/divide (HI/LO) unit with a busy counter. Branch and jump redirects resolved in EX take priority over all stalls, and a saturating stall counter supports performance measurement.

## Interface
Parameters:
- MD_LAT, 32, cycles the multiply/divide unit is busy after a start; legal range 2..63
- CNT_W, 6, width of the busy counter; must satisfy 2^CNT_W > MD_LAT

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_md  in  1  ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- ex_load  in  1  ID/EX holds a load (its DM read code is not NOP)
- ex_rd  in  5  destination register held in ID/EX (rt/rd/ra already selected)
- ex_md_start  in  1  EX instruction starts a multiply/divide this cycle
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- PCWr  out  1  PC register write enable
- IFIDWr  out  1  IF/ID register write enable
- IFIDFlush  out  1  IF/ID loads a NOP on the next edge
- IDEXFlush  out  1  ID/EX loads all-zero control (bubble) on the next edge
- md_busy  out  1  multiply/divide unit busy (state MD_WAIT)
- stall_cnt  out  16  cycles with PCWr=0 since reset, saturating

## Operation
- State machine: RUN, MD_WAIT. Busy counter md_cnt[CNT_W-1:0].
- RUN: if ex_md_start then md_cnt <= MD_LAT, go to MD_WAIT.
- MD_WAIT: md_cnt decrements each cycle; when md_cnt==1, next state is RUN and md_cnt becomes 0. ex_md_start in MD_WAIT is ignored; the counter is not reloaded.
- load_use = ex_load && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
- md_stall = (state==MD_WAIT) && id_md.
- Output priority, combinational from state and inputs:
  - rst=1: PCWr=0, IFIDWr=0, IFIDFlush=1, IDEXFlush=1.
  - ex_redirect: PCWr=1, IFIDWr=1, IFIDFlush=1, IDEXFlush=1 (kills the IF and ID instructions). Overrides both stall types.
  - md_stall or load_use: PCWr=0, IFIDWr=0, IFIDFlush=0, IDEXFlush=1 (holds IF/ID, inserts a bubble).
  - otherwise: PCWr=1, IFIDWr=1, both flushes 0.
- A register number 0 never produces a load-use hazard.
- Non-HI/LO instructions proceed through ID while md_busy=1.
- stall_cnt increments on every non-reset cycle with PCWr=0 and holds at 16'hFFFF.

## Timing
- Reset: state=RUN, md_cnt=0, stall_cnt=0, md_busy=0. Outputs follow the rst row while rst=1. rst takes effect mid-MD_WAIT and abandons the count.
- Load-use: one bubble. With stall at cycle t, the load leaves ID/EX at t+1, load_use drops, and the consumer enters EX at t+2. MEM/WB forwarding covers the rest.
- MD: ex_md_start at cycle t gives md_busy=1 for cycles t+1 .. t+MD_LAT and md_busy=0 at t+MD_LAT+1. An id_md instruction stalled in ID issues at t+MD_LAT+1.
- A redirect coinciding with ex_md_start still starts the counter, because the EX instruction is older and valid.
- Stall and redirect outputs are valid in the same cycle as their inputs, with no added latency.
- stall_cnt updates on the edge following a PCWr=0 cycle.

## Test plan
- Reset: hold rst 3 cycles during MD_WAIT, then release -> md_busy=0, stall_cnt=0, PCWr=1, IFIDWr=1, flushes 0 on the first post-reset cycle.
- Load-use: ex_load=1, ex_rd=8, id_rs=8, id_use_rs=1 for one cycle, then ex_load=0 -> exactly one cycle of PCWr=0/IFIDWr=0/IDEXFlush=1, stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- MD with MD_LAT=4: ex_md_start at t, id_md=1 from t+1 -> md_busy high t+1..t+4, PCWr=0 t+1..t+4, PCWr=1 at t+5, stall_cnt=4. With id_md=0 -> no stall, md_busy is still 4 cycles.
- Redirect priority: load_use=1 and ex_redirect=1 in the same cycle -> PCWr=1, IFIDFlush=1, IDEXFlush=1, stall_cnt unchanged.
- Ignored restart: ex_md_start pulsed at t+2 during MD_WAIT (MD_LAT=4) -> md_busy still falls at t+5.
- Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF and holds.
